// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end: request issue, PC-tagged in-order queue, redirect flush
module fetch_queue #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   mem_req_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] mem_rdata_i,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic [ADDR_WIDTH-1:0]  pc_plus4_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);
  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

  logic [ADDR_WIDTH-1:0]  fetchPc, respPc, redirectAligned;
  logic [CNT_W-1:0]       count, outstanding, discard;
  logic [CNT_W-1:0]       countNext, outstandingNext;
  logic [PTR_W-1:0]       rdPtr, wrPtr;
  logic [CNT_W:0]         inFlight;
  logic                   granted, respTaken, pushEn, popEn, headValid;

  logic [INSTR_WIDTH-1:0] instrMem [DEPTH];
  logic [ADDR_WIDTH-1:0]  pcMem    [DEPTH];

  assign redirectAligned = redirect_pc_i & ~ADDR_WIDTH'(3);
  assign inFlight        = {1'b0, count} + {1'b0, outstanding};

  // Gated by rst_i so the request drops the instant reset asserts.
  assign mem_req_o  = rst_i && !redirect_i && (inFlight < DEPTH_C);
  assign mem_addr_o = fetchPc;
  assign granted    = mem_req_o && mem_gnt_i;

  assign respTaken  = mem_rvalid_i && (outstanding != '0);
  assign pushEn     = respTaken && (discard == '0) && !redirect_i;
  assign headValid  = (count != '0);
  assign popEn      = headValid && instr_ready_i && !redirect_i;

  assign instr_valid_o = headValid;
  assign instr_o       = headValid ? instrMem[rdPtr] : NOP;
  assign pc_o          = headValid ? pcMem[rdPtr] : '0;
  assign pc_plus4_o    = pc_o + ADDR_WIDTH'(4);

  always_comb begin
    outstandingNext = outstanding + CNT_W'(granted) - CNT_W'(respTaken);
    countNext       = count + CNT_W'(pushEn) - CNT_W'(popEn);
    if (redirect_i) begin
      countNext = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rdPtr       <= '0;
      wrPtr       <= '0;
    end else begin
      outstanding <= outstandingNext;
      count       <= countNext;
      if (redirect_i) begin
        // Everything still in flight belongs to the old path, including earlier discards.
        fetchPc <= redirectAligned;
        respPc  <= redirectAligned;
        discard <= outstandingNext;
        rdPtr   <= '0;
        wrPtr   <= '0;
      end else begin
        if (granted) begin
          fetchPc <= fetchPc + ADDR_WIDTH'(4);
        end
        if (pushEn) begin
          respPc <= respPc + ADDR_WIDTH'(4);
          wrPtr  <= wrPtr + PTR_W'(1);
        end
        if (popEn) begin
          rdPtr <= rdPtr + PTR_W'(1);
        end
        if (respTaken && (discard != '0)) begin
          discard <= discard - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (pushEn) begin
      instrMem[wrPtr] <= mem_rdata_i;
      pcMem[wrPtr]    <= respPc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue with a variable-latency memory model
module tb_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;

  fetch_queue dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o)
  );

  initial forever #5 clk_i = ~clk_i;

  // Memory model: in-order responses, data equals address, fixed latency per scenario.
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];
  int cyc = 0;
  int grants = 0;
  int lat = 1;

  always @(negedge clk_i) begin
    cyc++;
    if (!rst_i) begin
      pend.delete();
      mem_rvalid_i = 1'b0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = pend[0].addr;
    end else begin
      mem_rvalid_i = 1'b0;
    end
    #2;
    if (rst_i && mem_rvalid_i) void'(pend.pop_front());
    if (rst_i && mem_req_o && mem_gnt_i) begin
      pend.push_back('{mem_addr_o, cyc + lat});
      grants++;
    end
  end

  typedef struct {
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
  } vec_t;
  vec_t vecs [6];

  logic [31:0] expQ[$];
  int errors = 0;
  int checks = 0;
  int g0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout, %0d entries still expected", name, expQ.size());
  endtask

  task automatic popCheck();
    logic [31:0] e;
    if (rst_i && instr_valid_o && instr_ready_i && !redirect_i) begin
      if (expQ.size() == 0) begin
        chk("unexpected_pop_pc", pc_o, 32'hFFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        chk("pop_pc", pc_o, e);
        chk("pop_instr", instr_o, e);
        chk("pop_pc_plus4", pc_plus4_o, e + 32'd4);
      end
    end
  endtask

  task automatic step();
    #2 popCheck();
    @(negedge clk_i);
  endtask

  task automatic waitEmpty(input int budget, input string name);
    for (int i = 0; i < budget && expQ.size() > 0; i++) step();
    if (expQ.size() > 0) failNow(name);
    instr_ready_i = 1'b0;
  endtask

  task automatic doReset();
    rst_i = 1'b0;
    expQ.delete();
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    g0 = grants;
  endtask

  initial begin
    rst_i = 1'b0; mem_gnt_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = '0; instr_ready_i = 1'b0;

    vecs[0] = '{1'b1, 32'd0,  1'b0, 32'd0};
    vecs[1] = '{1'b1, 32'd4,  1'b0, 32'd0};
    vecs[2] = '{1'b1, 32'd8,  1'b1, 32'd0};
    vecs[3] = '{1'b1, 32'd12, 1'b1, 32'd4};
    vecs[4] = '{1'b1, 32'd16, 1'b1, 32'd8};
    vecs[5] = '{1'b1, 32'd20, 1'b1, 32'd12};

    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'h0000_0013);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_pc_plus4", pc_plus4_o, 32'd4);
    @(negedge clk_i);

    // Streaming, 1-cycle latency
    lat = 1;
    doReset();
    mem_gnt_i = 1'b1; instr_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) expQ.push_back(32'(i * 4));
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      #1;
      chk("stream_req", {31'd0, mem_req_o}, {31'd0, vecs[i].expReq});
      chk("stream_addr", mem_addr_o, vecs[i].expAddr);
      chk("stream_valid", {31'd0, instr_valid_o}, {31'd0, vecs[i].expValid});
      chk("stream_pc", pc_o, vecs[i].expPc);
      chk("stream_instr", instr_o, vecs[i].expValid ? vecs[i].expPc : 32'h13);
      chk("stream_pc_plus4", pc_plus4_o, vecs[i].expPc + 32'd4);
    end
    waitEmpty(40, "stream_drain");

    // Backpressure fills to DEPTH, then drains in order and resumes at 16
    doReset();
    mem_gnt_i = 1'b1; instr_ready_i = 1'b0;
    repeat (8) step();
    #1;
    chk("bp_grants", 32'(grants - g0), 32'd4);
    chk("bp_req", {31'd0, mem_req_o}, 32'd0);
    chk("bp_addr", mem_addr_o, 32'd16);
    chk("bp_head_pc", pc_o, 32'd0);
    for (int i = 0; i < 6; i++) expQ.push_back(32'(i * 4));
    instr_ready_i = 1'b1;
    waitEmpty(30, "bp_drain");

    // Redirect with two responses in flight, 3-cycle latency
    lat = 3;
    doReset();
    mem_gnt_i = 1'b1; instr_ready_i = 1'b1;
    expQ.push_back(32'h100); expQ.push_back(32'h104); expQ.push_back(32'h108);
    step(); step();
    mem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h100;
    #1 chk("redir_req_low", {31'd0, mem_req_o}, 32'd0);
    step();
    redirect_i = 1'b0; mem_gnt_i = 1'b1;
    #1;
    chk("redir_addr", mem_addr_o, 32'h100);
    chk("redir_req", {31'd0, mem_req_o}, 32'd1);
    chk("redir_flushed", {31'd0, instr_valid_o}, 32'd0);
    waitEmpty(40, "redir_drain");

    // Redirect coincident with rvalid, plus a later stale response; unaligned target
    lat = 2;
    doReset();
    mem_gnt_i = 1'b1; instr_ready_i = 1'b1;
    expQ.push_back(32'h100); expQ.push_back(32'h104);
    step(); step();
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    #1 chk("coinc_rvalid_req", {31'd0, mem_req_o}, 32'd0);
    step();
    redirect_i = 1'b0;
    #1 chk("coinc_addr", mem_addr_o, 32'h100);
    waitEmpty(40, "coinc_drain");

    // Grant stall holds the request
    lat = 1;
    doReset();
    mem_gnt_i = 1'b0; instr_ready_i = 1'b1;
    expQ.push_back(32'd0); expQ.push_back(32'd4); expQ.push_back(32'd8);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      #1;
      chk("stall_req", {31'd0, mem_req_o}, 32'd1);
      chk("stall_addr", mem_addr_o, 32'd0);
    end
    step();
    mem_gnt_i = 1'b1;
    step();
    #1;
    chk("stall_grants", 32'(grants - g0), 32'd1);
    chk("stall_next_addr", mem_addr_o, 32'd4);
    waitEmpty(30, "stall_drain");

    // Async reset mid-operation with count=3, outstanding=1
    lat = 1;
    doReset();
    mem_gnt_i = 1'b1; instr_ready_i = 1'b0;
    repeat (4) step();
    #1;
    chk("ar_pre_valid", {31'd0, instr_valid_o}, 32'd1);
    chk("ar_pre_pc", pc_o, 32'd0);
    #2 rst_i = 1'b0;
    #1;
    chk("ar_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("ar_req", {31'd0, mem_req_o}, 32'd0);
    chk("ar_instr", instr_o, 32'h0000_0013);
    chk("ar_pc", pc_o, 32'd0);
    @(negedge clk_i);
    doReset();
    expQ.push_back(32'd0); expQ.push_back(32'd4); expQ.push_back(32'd8);
    instr_ready_i = 1'b1;
    #1;
    chk("ar_restart_addr", mem_addr_o, 32'd0);
    chk("ar_restart_req", {31'd0, mem_req_o}, 32'd1);
    waitEmpty(30, "ar_drain");

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
